mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 202 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_div_unit : iterative HI/LO multiply/divide unit, one bit per cycle.    |
// | Optional divider datapath is built when MD_DIV_EN is defined.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            W_start,
    input  logic [1:0]      W_op,
    input  logic [XLEN-1:0] W_rs,
    input  logic [XLEN-1:0] W_rt,
    input  logic [1:0]      W_hilo_wea,
    input  logic [XLEN-1:0] W_hilo_data,
    output logic            MD_busy,
    output logic            MD_done,
    output logic [XLEN-1:0] MD_hi,
    output logic [XLEN-1:0] MD_lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(XLEN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;

    logic [XLEN-1:0]   r_m;
    logic [XLEN-1:0]   r_acc_hi;
    logic [XLEN-1:0]   r_acc_lo;
    logic              r_neg_q;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic              r_done;

    logic              w_op_ok;
    logic              w_accept;
    logic              w_rs_neg;
    logic              w_rt_neg;
    logic [XLEN-1:0]   w_rs_mag;
    logic [XLEN-1:0]   w_rt_mag;
    logic [XLEN:0]     w_sum;
    logic [XLEN-1:0]   w_step_hi;
    logic [XLEN-1:0]   w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_fix_hi;
    logic [XLEN-1:0]   w_fix_lo;

`ifdef MD_DIV_EN
    logic              r_is_div;
    logic              r_neg_r;
    logic              r_div0;
    logic [XLEN-1:0]   r_rs;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;

    assign w_op_ok = 1'b1;
`else
    // Without the divider, DIV/DIVU requests are simply never accepted.
    assign w_op_ok = ~W_op[1];
`endif

    assign w_accept = (r_state == S_IDLE) & W_start & w_op_ok;
    assign MD_busy  = (r_state != S_IDLE);
    assign MD_done  = r_done;
    assign MD_hi    = r_hi;
    assign MD_lo    = r_lo;

    // W_op[0] clear selects the signed flavour of either operation.
    assign w_rs_neg = ~W_op[0] & W_rs[XLEN-1];
    assign w_rt_neg = ~W_op[0] & W_rt[XLEN-1];
    assign w_rs_mag = w_rs_neg ? -W_rs : W_rs;
    assign w_rt_mag = w_rt_neg ? -W_rt : W_rt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_RUN && r_cnt != C_LAST_ITER) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (r_cnt == C_LAST_ITER) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shift-add step: {carry, acc_hi, acc_lo} shifts right once per cycle.
    always_comb begin
        w_sum     = r_acc_lo[0] ? ({1'b0, r_acc_hi} + {1'b0, r_m}) : {1'b0, r_acc_hi};
        w_step_hi = w_sum[XLEN:1];
        w_step_lo = {w_sum[0], r_acc_lo[XLEN-1:1]};
`ifdef MD_DIV_EN
        // Restoring step: acc_hi holds the partial remainder, acc_lo the dividend/quotient.
        w_shift = {r_acc_hi, r_acc_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_m};
        w_ge    = ~w_diff[XLEN];
        if (r_is_div) begin
            w_step_hi = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
            w_step_lo = {r_acc_lo[XLEN-2:0], w_ge};
        end
`endif
    end

    always_comb begin
        w_prod   = {r_acc_hi, r_acc_lo};
        w_prod   = r_neg_q ? -w_prod : w_prod;
        w_fix_hi = w_prod[2*XLEN-1:XLEN];
        w_fix_lo = w_prod[XLEN-1:0];
`ifdef MD_DIV_EN
        if (r_is_div) begin
            if (r_div0) begin
                w_fix_hi = r_rs;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = r_neg_r ? -r_acc_hi : r_acc_hi;
                w_fix_lo = r_neg_q ? -r_acc_lo : r_acc_lo;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_m      <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_neg_q  <= 1'b0;
        end else if (w_accept) begin
            r_acc_hi <= '0;
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
`ifdef MD_DIV_EN
            r_m      <= W_op[1] ? w_rt_mag : w_rs_mag;
            r_acc_lo <= W_op[1] ? w_rs_mag : w_rt_mag;
`else
            r_m      <= w_rs_mag;
            r_acc_lo <= w_rt_mag;
`endif
        end else if (r_state == S_RUN) begin
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
        end
    end

`ifdef MD_DIV_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_div <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_rs     <= '0;
        end else if (w_accept) begin
            r_is_div <= W_op[1];
            r_neg_r  <= w_rs_neg;
            r_div0   <= (W_rt == '0);
            r_rs     <= W_rs;
        end
    end
`endif

    // Architectural HI/LO change only at the end of FIX or on an idle direct write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else if (r_state == S_FIX) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE && !w_accept) begin
                if (W_hilo_wea[1]) r_hi <= W_hilo_data;
                if (W_hilo_wea[0]) r_lo <= W_hilo_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mul_div_unit : directed + random checks of mul_div_unit vs. arithmetic. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_mul_div_unit;

    localparam int XLEN = 32;
`ifdef MD_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [1:0]      op = '0;
    logic [XLEN-1:0] rs = '0;
    logic [XLEN-1:0] rt = '0;
    logic [1:0]      wea = '0;
    logic [XLEN-1:0] wdata = '0;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    int vectors = 0;
    int miscompares = 0;

    mul_div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .W_start     (start),
        .W_op        (op),
        .W_rs        (rs),
        .W_rt        (rt),
        .W_hilo_wea  (wea),
        .W_hilo_data (wdata),
        .MD_busy     (busy),
        .MD_done     (done),
        .MD_hi       (hi),
        .MD_lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: results straight from integer arithmetic rules.
    function automatic bit model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] eh, output logic [31:0] el);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        eh = '0;
        el = '0;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                {eh, el} = sp;
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                {eh, el} = up;
            end
            2'b10: begin
                if (!DIV_EN) return 1'b0;
                if (sb == 0) begin
                    eh = a; el = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    eh = 32'd0; el = 32'h8000_0000;
                end else begin
                    el = sa / sb; eh = sa % sb;
                end
            end
            default: begin
                if (!DIV_EN) return 1'b0;
                if (b == 0) begin
                    eh = a; el = 32'hFFFF_FFFF;
                end else begin
                    el = a / b; eh = a % b;
                end
            end
        endcase
        return 1'b1;
    endfunction

    // Issues one operation, returns in the cycle after done (or after the ignore window).
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] ph;
        logic [31:0] pl;
        bit          acc;
        bit          stable;
        bit          seen;
        int          n;
        ph  = hi;
        pl  = lo;
        acc = model(o, a, b, eh, el);
        op = o; rs = a; rt = b; start = 1'b1;
        tick();
        start = 1'b0; op = 2'($urandom); rs = $urandom; rt = $urandom;
        if (acc) begin
            check({tag, " busy"}, 64'(busy), 64'(1));
            n = 1;
            stable = 1'b1;
            while (!done && n < 60) begin
                if (hi !== ph || lo !== pl) stable = 1'b0;
                tick();
                n++;
            end
            check({tag, " latency"}, 64'(n), 64'(XLEN + 2));
            check({tag, " hold"}, 64'(stable), 64'(1));
            check({tag, " hi"}, 64'(hi), 64'(eh));
            check({tag, " lo"}, 64'(lo), 64'(el));
            check({tag, " idle at done"}, 64'(busy), 64'(0));
            tick();
            check({tag, " done pulse"}, 64'(done), 64'(0));
        end else begin
            check({tag, " ignored busy"}, 64'(busy), 64'(0));
            seen = 1'b0;
            repeat (4) begin
                tick();
                if (done || busy) seen = 1'b1;
            end
            check({tag, " ignored activity"}, 64'(seen), 64'(0));
            check({tag, " ignored hilo"}, {32'(hi), 32'(lo)}, {ph, pl});
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          n;
        bit          seen;

        #2;
        rst = 1'b0;
        #1;
        check("reset state", {28'd0, busy, done, 2'b00, 32'(hi ^ lo)}, 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        repeat (2) tick();
        rst = 1'b1;

        do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, "mult neg");
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult minmin");
        do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "div neg");
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
        do_op(2'b11, 32'h0000_0007, 32'h0000_0000, "divu zero");
        do_op(2'b10, 32'h0000_0064, 32'hFFFF_FFF9, "div negdiv");

        // Direct writes in idle.
        wea = 2'b10; wdata = 32'hA5A5_0001;
        tick();
        wea = 2'b01; wdata = 32'h5A5A_0002;
        tick();
        wea = 2'b00;
        check("mthi mtlo", {hi, lo}, 64'hA5A5_0001_5A5A_0002);

        // Start with a same-cycle direct write, then a start+write pulse mid-operation.
        op = 2'b01; rs = 32'd2; rt = 32'd3; start = 1'b1; wea = 2'b11; wdata = 32'h1111_2222;
        tick();
        start = 1'b0; wea = 2'b00;
        check("accept drops write", {hi, lo}, 64'hA5A5_0001_5A5A_0002);
        n = 1;
        repeat (9) begin tick(); n++; end
        op = 2'b00; rs = 32'hDEAD_BEEF; rt = 32'h7; start = 1'b1; wea = 2'b11; wdata = 32'hDEAD_BEEF;
        tick();
        n++;
        start = 1'b0; wea = 2'b00;
        check("busy write dropped", {hi, lo}, 64'hA5A5_0001_5A5A_0002);
        while (!done && n < 60) begin tick(); n++; end
        check("busy start latency", 64'(n), 64'(XLEN + 2));
        check("busy start result", {hi, lo}, 64'h0000_0000_0000_0006);
        tick();

        // Asynchronous reset in the middle of an operation.
        wea = 2'b11; wdata = 32'h1234_5678;
        tick();
        wea = 2'b00;
        op = DIV_EN ? 2'b10 : 2'b01; rs = 32'hFFFF_FFF9; rt = 32'h2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        rst = 1'b0;
        #1;
        check("abort outputs", {29'd0, busy, done, 1'b0, 32'(hi | lo)}, 64'd0);
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (done || busy) seen = 1'b1;
        end
        check("abort no done", 64'(seen), 64'(0));
        #2;
        rst = 1'b1;
        do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, "mult after reset");

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (i % 7 == 0) rb = 32'd0;
            if (i % 5 == 2) rb = rb >> $urandom_range(0, 31);
            if (i % 11 == 3) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            do_op(ro, ra, rb, $sformatf("rand%0d op%0d", i, ro));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
